// File: rtl/xbus_dec_pkg.sv
// Shared bus-decoder definitions: default widths, control-region base and
// offsets, status word bit positions, and the soft-reset FSM state type.
package xbus_dec_pkg;

  localparam int XBUS_ADDR_W = 16;
  localparam int XBUS_DATA_W = 16;
  localparam logic [XBUS_ADDR_W-1:0] BUSCTRL_BASE = 16'h0FFE;

  // Control region is two words; address bit 0 selects the word.
  localparam logic CTRL_OFS_STATUS = 1'b0;
  localparam logic CTRL_OFS_ERR    = 1'b1;

  localparam int STAT_ERR_FLAG_BIT = 7;
  localparam int STAT_ERR_CNT_LSB  = 8;

  localparam int RST_CNT_W = 4;

  typedef enum logic {
    RP_IDLE  = 1'b0,
    RP_PULSE = 1'b1
  } rp_state_e;

endpackage

// File: rtl/xbus_dec_xrstpulse.sv
// Per-slot soft-reset pulse generator: a start request produces RST_PULSE
// cycles of busy, and a start while busy restarts the full pulse.
//   state    | meaning
//   RP_IDLE  | no pulse in progress, counter 0
//   RP_PULSE | busy high, counter holds cycles remaining including this one
module xrstpulse
  import xbus_dec_pkg::*;
#(
  parameter int RST_PULSE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  rp_state_e              r_state;
  rp_state_e              w_state_nxt;
  logic [RST_CNT_W-1:0]   r_cnt;
  logic [RST_CNT_W-1:0]   w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RP_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (start) begin
      w_state_nxt = RP_PULSE;
      w_cnt_nxt   = RST_CNT_W'(RST_PULSE);
    end else if (r_state == RP_PULSE) begin
      if (r_cnt == RST_CNT_W'(1)) begin
        w_state_nxt = RP_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - RST_CNT_W'(1);
      end
    end
  end

  assign busy = (r_state == RP_PULSE);

endmodule

// File: rtl/xbus_dec.sv
// Address decoder for a small controller bus: per-slot selects and read-data
// mux, a two-word control region for soft resets and unmapped-access logging.
module xbus_dec
  import xbus_dec_pkg::*;
#(
  parameter int                     NSLV      = 4,
  parameter int                     ADDR_W    = XBUS_ADDR_W,
  parameter int                     DATA_W    = XBUS_DATA_W,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE  = '0,
  parameter logic [NSLV*8-1:0]      SLV_AW    = '0,
  parameter logic [ADDR_W-1:0]      CTRL_BASE = ADDR_W'(BUSCTRL_BASE),
  parameter bit                     RD_REG    = 1'b0,
  parameter int                     RST_PULSE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_sel,
  input  logic                   data_we,
  input  logic [ADDR_W-1:0]      data_addr,
  input  logic [DATA_W-1:0]      data_to_wr,
  output logic [DATA_W-1:0]      data_to_rd,
  output logic [NSLV-1:0]        slv_sel,
  output logic [NSLV-1:0]        slv_rst,
  input  logic [NSLV*DATA_W-1:0] slv_data_in
);

  localparam int XW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [NSLV-1:0]   w_hit;
  logic [NSLV-1:0]   w_win;
  logic [NSLV-1:0]   w_busy;
  logic [NSLV-1:0]   w_start;
  logic              w_ctrl_hit;
  logic              w_ctrl_wr;
  logic              w_unmapped;
  logic              w_err_clr;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_errword;
  logic [DATA_W-1:0] w_rdata;
  logic [XW-1:0]     w_ea_ext;
  logic              w_unused_wdata;

  logic              r_err_flag;
  logic [7:0]        r_err_cnt;
  logic [ADDR_W-1:0] r_err_addr;

  function automatic logic [ADDR_W-1:0] slot_mask(input logic [7:0] aw);
    return {ADDR_W{1'b1}} << aw;
  endfunction

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_hit[i] = (data_addr & slot_mask(SLV_AW[i*8 +: 8])) == SLV_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  // Scan high-to-low so the lowest-index overlapping slot ends up winning.
  always_comb begin
    w_win = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win    = '0;
        w_win[i] = 1'b1;
      end
    end
  end

  assign w_ctrl_hit = (data_addr[ADDR_W-1:1] == CTRL_BASE[ADDR_W-1:1]);
  assign slv_sel    = (data_sel && !w_ctrl_hit) ? w_win : '0;
  assign w_unmapped = data_sel && !w_ctrl_hit && (w_hit == '0);
  assign w_ctrl_wr  = data_sel && data_we && w_ctrl_hit;
  assign w_err_clr  = w_ctrl_wr && (data_addr[0] == CTRL_OFS_ERR);
  assign w_start    = (w_ctrl_wr && (data_addr[0] == CTRL_OFS_STATUS)) ?
                      data_to_wr[NSLV-1:0] : '0;
  assign w_unused_wdata = ^data_to_wr[DATA_W-1:NSLV];

  always_comb begin
    w_status = '0;
    w_status[NSLV-1:0]                = w_busy;
    w_status[STAT_ERR_FLAG_BIT]       = r_err_flag;
    w_status[STAT_ERR_CNT_LSB +: 8]   = r_err_cnt;
  end

  assign w_ea_ext  = XW'(r_err_addr);
  assign w_errword = w_ea_ext[DATA_W-1:0];

  always_comb begin
    w_rdata = '0;
    if (w_ctrl_hit) begin
      w_rdata = (data_addr[0] == CTRL_OFS_ERR) ? w_errword : w_status;
    end else begin
      for (int i = 0; i < NSLV; i++) begin
        if (w_win[i]) w_rdata = w_rdata | slv_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else if (w_err_clr) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else if (w_unmapped) begin
      r_err_flag <= 1'b1;
      r_err_addr <= data_addr;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  generate
    if (RD_REG) begin : g_rd_reg
      logic [DATA_W-1:0] r_rdata;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_rdata <= '0;
        else if (data_sel) r_rdata <= w_rdata;
      end
      assign data_to_rd = r_rdata;
    end else begin : g_rd_comb
      assign data_to_rd = w_rdata;
    end
  endgenerate

  for (genvar i = 0; i < NSLV; i++) begin : g_rp
    xrstpulse #(.RST_PULSE(RST_PULSE)) u_rp (
      .clk   (clk),
      .rst   (rst),
      .start (w_start[i]),
      .busy  (w_busy[i])
    );
  end

  // Slaves are held in reset for the whole of a bus reset, not only pulses.
  assign slv_rst = w_busy | {NSLV{rst}};

endmodule

// File: tb/tb_xbus_dec.sv
// Directed bench for xbus_dec: instance A is combinational-read with distinct
// slot bases, instance B is registered-read with slot 2 overlapping slot 0.
module tb_xbus_dec;

  logic        clk;
  logic        rst;
  logic        data_sel;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_to_wr;
  logic [63:0] slv_data_in;

  logic [15:0] a_rd, b_rd;
  logic [3:0]  a_sel, b_sel, a_rst, b_rst;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t q_exp[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [15:0] CTRL = 16'h0FFE;

  xbus_dec #(
    .NSLV(4), .ADDR_W(16), .DATA_W(16),
    .SLV_BASE(64'h0400_0300_0200_0100), .SLV_AW(32'h0000_0004),
    .CTRL_BASE(16'h0FFE), .RD_REG(1'b0), .RST_PULSE(4)
  ) u_a (
    .clk(clk), .rst(rst), .data_sel(data_sel), .data_we(data_we),
    .data_addr(data_addr), .data_to_wr(data_to_wr), .data_to_rd(a_rd),
    .slv_sel(a_sel), .slv_rst(a_rst), .slv_data_in(slv_data_in)
  );

  xbus_dec #(
    .NSLV(4), .ADDR_W(16), .DATA_W(16),
    .SLV_BASE(64'h0400_0100_0200_0100), .SLV_AW(32'h0000_0004),
    .CTRL_BASE(16'h0FFE), .RD_REG(1'b1), .RST_PULSE(4)
  ) u_b (
    .clk(clk), .rst(rst), .data_sel(data_sel), .data_we(data_we),
    .data_addr(data_addr), .data_to_wr(data_to_wr), .data_to_rd(b_rd),
    .slv_sel(b_sel), .slv_rst(b_rst), .slv_data_in(slv_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic s, input logic w, input logic [15:0] a,
                       input logic [15:0] d);
    data_sel   = s;
    data_we    = w;
    data_addr  = a;
    data_to_wr = d;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    q_exp.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (q_exp.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = q_exp.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    slv_data_in = {16'h4444, 16'h3333, 16'hCAFE, 16'h1111};
    repeat (2) @(negedge clk);

    push("rst_slv_rst_a", 32'hF);  check(32'(a_rst));
    push("rst_slv_rst_b", 32'hF);  check(32'(b_rst));
    push("rst_rd_reg_b",  32'h0);  check(32'(b_rd));
    rst = 1'b0;
    @(negedge clk);
    push("post_rst_slv_rst", 32'h0); check(32'(a_rst));

    // Combinational decode and read mux
    drive(1'b1, 1'b0, 16'h010A, 16'h0000); #1;
    push("rd_10a_sel",  32'h1);    check(32'(a_sel));
    push("rd_10a_data", 32'h1111); check(32'(a_rd));
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0300, 16'h0000); #1;
    push("rd_300_sel",  32'h4);    check(32'(a_sel));
    push("rd_300_data", 32'h3333); check(32'(a_rd));

    // Registered read: previous access (0x300) is unmapped in B, so 0 before the edge
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0200, 16'h0000); #1;
    push("reg_rd_pre", 32'h0); check(32'(b_rd));
    push("reg_rd_lat", 32'hCAFE);
    @(posedge clk); #1;
    check(32'(b_rd));
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk); #1;
    push("reg_rd_hold", 32'hCAFE); check(32'(b_rd));

    // Overlapping slots in B: slot 0 must win over slot 2
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0100, 16'h0000); #1;
    push("overlap_sel", 32'h1); check(32'(b_sel));

    // Soft-reset pulse of 4 cycles, status visible while busy
    @(negedge clk);
    drive(1'b1, 1'b1, CTRL, 16'h0005);
    @(negedge clk);
    drive(1'b1, 1'b0, CTRL, 16'h0000); #1;
    push("status_busy", 32'h0005); check(32'(a_rd));
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("pulse_c%0d", k), (k <= 4) ? 32'h5 : 32'h0);
      check(32'(a_rst));
      @(negedge clk);
    end

    // Restart during cycle 2 stretches the pulse to 6 cycles
    drive(1'b1, 1'b1, CTRL, 16'h0005);
    @(negedge clk);
    for (int k = 1; k <= 7; k++) begin
      push($sformatf("restart_c%0d", k), (k <= 6) ? 32'h5 : 32'h0);
      check(32'(a_rst));
      if (k == 2) drive(1'b1, 1'b1, CTRL, 16'h0005);
      else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
    end

    // Unmapped accesses: last address wins, count accumulates
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, (k < 3) ? 16'h0999 : 16'h0998, 16'h0000);
      @(negedge clk);
    end
    drive(1'b1, 1'b0, CTRL, 16'h0000); #1;
    push("err_status", 32'h0580); check(32'(a_rd));
    @(negedge clk);
    drive(1'b1, 1'b0, CTRL + 16'h1, 16'h0000); #1;
    push("err_addr", 32'h0998); check(32'(a_rd));
    @(negedge clk);
    drive(1'b1, 1'b1, CTRL + 16'h1, 16'h1234);
    @(negedge clk);
    drive(1'b1, 1'b0, CTRL, 16'h0000); #1;
    push("clr_status", 32'h0000); check(32'(a_rd));
    @(negedge clk);
    drive(1'b1, 1'b0, CTRL + 16'h1, 16'h0000); #1;
    push("clr_addr", 32'h0000); check(32'(a_rd));
    @(negedge clk);

    // Saturation after 300 unmapped reads and writes
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, k[0], 16'h0999, 16'h0000);
      @(negedge clk);
    end
    drive(1'b1, 1'b0, CTRL, 16'h0000); #1;
    push("sat_status", 32'hFF80); check(32'(a_rd));
    @(negedge clk);
    drive(1'b1, 1'b0, CTRL + 16'h1, 16'h0000); #1;
    push("sat_addr", 32'h0999); check(32'(a_rd));
    @(negedge clk);

    // Bus reset in the middle of a pulse aborts it
    drive(1'b1, 1'b1, CTRL, 16'h000F);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    push("mid_pulse", 32'hF); check(32'(a_rst));
    rst = 1'b1; #1;
    push("rst_during_pulse", 32'hF); check(32'(a_rst));
    @(negedge clk);
    push("rst_held", 32'hF); check(32'(a_rst));
    rst = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      push($sformatf("after_rst_c%0d", k), 32'h0);
      check(32'(a_rst));
      @(negedge clk);
    end
    drive(1'b1, 1'b0, CTRL, 16'h0000); #1;
    push("after_rst_status", 32'h0000); check(32'(a_rd));
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
